// File: rtl/crack_collector.sv
// crack_collector
//   Starts all ARC4 crack cores together, watches their rdy/key_valid pairs,
//   picks the lowest-index core that reports a valid key, latches its key and
//   copies that core's local plaintext memory (length byte at address 0 plus
//   message bytes) into the shared output PT memory.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   en, msg_len       start request (taken only in IDLE) and message length
//   rdy               high in IDLE, DONE_GOOD, DONE_BAD
//   key, key_valid    winning key; valid only in DONE_GOOD
//   core_en           one-cycle start pulse to every core
//   core_rdy          per-core rdy
//   core_key_valid    per-core key_valid
//   core_key          per-core key, core i at [24i+23:24i]
//   core_pt_addr      read address broadcast to all core PT memories
//   core_pt_rddata    per-core PT read data, core i at [8i+7:8i], 1-cycle latency
//   pt_addr, pt_wrdata, pt_wren   shared output PT memory write port
module crack_collector #(
  parameter int NUM_CORES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [7:0]              msg_len,
  output logic                    rdy,
  output logic [23:0]             key,
  output logic                    key_valid,
  output logic [NUM_CORES-1:0]    core_en,
  input  logic [NUM_CORES-1:0]    core_rdy,
  input  logic [NUM_CORES-1:0]    core_key_valid,
  input  logic [24*NUM_CORES-1:0] core_key,
  output logic [7:0]              core_pt_addr,
  input  logic [8*NUM_CORES-1:0]  core_pt_rddata,
  output logic [7:0]              pt_addr,
  output logic [7:0]              pt_wrdata,
  output logic                    pt_wren
);

  localparam int WW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_COPY      = 3'd3;
  localparam logic [2:0] S_DONE_GOOD = 3'd4;
  localparam logic [2:0] S_DONE_BAD  = 3'd5;

  logic [2:0]           state;
  logic [7:0]           len_q;
  logic [23:0]          key_q;
  logic [WW-1:0]        win_q;
  logic [7:0]           rd_cnt;
  logic                 rd_done;
  logic [NUM_CORES-1:0] core_en_q;
  logic                 wr_vld;
  logic [7:0]           wr_addr_q;

  logic [NUM_CORES-1:0] hit;
  logic                 any_hit;
  logic [WW-1:0]        win_idx;
  logic [23:0]          win_key;
  logic [7:0]           rd_sel;

  assign hit = core_rdy & core_key_valid;

  // Lowest index wins when several cores hit in the same cycle.
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    win_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit[i] && !any_hit) begin
        any_hit = 1'b1;
        win_idx = WW'(i);
        win_key = core_key[24*i +: 24];
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (win_q == WW'(i)) rd_sel = core_pt_rddata[8*i +: 8];
    end
  end

  assign rdy          = (state == S_IDLE) || (state == S_DONE_GOOD) || (state == S_DONE_BAD);
  assign key_valid    = (state == S_DONE_GOOD);
  assign key          = (state == S_DONE_GOOD) ? key_q : '0;
  assign core_en      = core_en_q;
  assign core_pt_addr = rd_cnt;
  assign pt_addr      = wr_addr_q;
  assign pt_wren      = wr_vld;
  // Read data arrives one cycle after its address, which lines up with the
  // registered write address/enable; gating keeps the port quiet otherwise.
  assign pt_wrdata    = wr_vld ? rd_sel : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      key_q     <= '0;
      win_q     <= '0;
      rd_cnt    <= '0;
      rd_done   <= 1'b0;
      core_en_q <= '0;
      wr_vld    <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      core_en_q <= '0;
      wr_vld    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && (&core_rdy)) begin
            len_q     <= msg_len;
            core_en_q <= '1;
            state     <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (any_hit) begin
            key_q   <= win_key;
            win_q   <= win_idx;
            rd_cnt  <= '0;
            rd_done <= 1'b0;
            state   <= S_COPY;
          end else if (&core_rdy) begin
            state <= S_DONE_BAD;
          end
        end
        S_COPY: begin
          // Read stage issues addresses 0..len_q; the cycle after the last
          // read carries the final write and then the block finishes.
          if (!rd_done) begin
            wr_vld    <= 1'b1;
            wr_addr_q <= rd_cnt;
            if (rd_cnt == len_q) rd_done <= 1'b1;
            else                 rd_cnt  <= rd_cnt + 8'd1;
          end else begin
            state <= S_DONE_GOOD;
          end
        end
        S_DONE_GOOD, S_DONE_BAD: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crack_collector.sv
// tb_crack_collector
//   Directed bench for crack_collector with two behavioural crack cores and
//   their plaintext memories. Each case programs the cores' run length,
//   hit/miss outcome and key, starts the collector and compares the outcome
//   and the logged output-memory writes against hand-derived values.
module tb_crack_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  msg_len = '0;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic [1:0]  core_en;
  logic [1:0]  core_rdy;
  logic [1:0]  core_key_valid;
  logic [47:0] core_key;
  logic [7:0]  core_pt_addr;
  logic [15:0] core_pt_rddata;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;

  crack_collector #(.NUM_CORES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .msg_len(msg_len),
    .rdy(rdy), .key(key), .key_valid(key_valid), .core_en(core_en),
    .core_rdy(core_rdy), .core_key_valid(core_key_valid), .core_key(core_key),
    .core_pt_addr(core_pt_addr), .core_pt_rddata(core_pt_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // Per-case core programming (written only by the stimulus process).
  int          cfg_delay [2];
  logic [1:0]  cfg_hit = '0;
  logic [23:0] cfg_key [2];
  logic [1:0]  force_busy = '0;
  logic [7:0]  cur_len = '0;

  // Core model state (written only by the model process).
  logic [1:0]  m_rdy = 2'b11;
  logic [1:0]  m_kv  = 2'b00;
  int          m_cnt [2];
  logic [7:0]  rd0 = '0, rd1 = '0;

  assign core_rdy       = m_rdy & ~force_busy;
  assign core_key_valid = m_kv;
  assign core_key       = {cfg_key[1], cfg_key[0]};
  assign core_pt_rddata = {rd1, rd0};

  function automatic logic [7:0] mem_byte(input int c, input logic [7:0] a);
    if (a == 8'd0) return cur_len;
    return a ^ ((c == 1) ? 8'hC3 : 8'h3C);
  endfunction

  always @(posedge clk) begin
    rd0 <= mem_byte(0, core_pt_addr);
    rd1 <= mem_byte(1, core_pt_addr);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_rdy[i] <= 1'b1;
        m_kv[i]  <= 1'b0;
        m_cnt[i] <= 0;
      end else if (core_en[i]) begin
        m_rdy[i] <= 1'b0;
        m_kv[i]  <= 1'b0;
        m_cnt[i] <= cfg_delay[i];
      end else if (!m_rdy[i]) begin
        if (m_cnt[i] == 0) begin
          m_rdy[i] <= 1'b1;
          m_kv[i]  <= cfg_hit[i];
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  // Output monitor: cumulative logs, sampled on the falling edge.
  int          cyc = 0;
  int          wr_n = 0;
  int          en_pulses = 0;
  logic [1:0]  last_en = '0;
  logic [7:0]  wr_addr_log [2048];
  logic [7:0]  wr_data_log [2048];
  int          wr_cyc_log  [2048];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pt_wren && wr_n < 2048) begin
      wr_addr_log[wr_n] <= pt_addr;
      wr_data_log[wr_n] <= pt_wrdata;
      wr_cyc_log[wr_n]  <= cyc;
      wr_n              <= wr_n + 1;
    end
    if (core_en != 2'b00) begin
      en_pulses <= en_pulses + 1;
      last_en   <= core_en;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_en(input logic [7:0] len);
    msg_len = len;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdy) begin ok = 1'b1; break; end
    end
    check({tag, "_done_timeout"}, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_case(input string tag, input logic [7:0] len,
                          input int d0, input bit h0, input logic [23:0] k0,
                          input int d1, input bit h1, input logic [23:0] k1,
                          input bit exp_good, input int exp_win,
                          input logic [23:0] exp_key);
    int base_w, base_e, nw, errs;
    cfg_delay[0] = d0; cfg_hit[0] = h0; cfg_key[0] = k0;
    cfg_delay[1] = d1; cfg_hit[1] = h1; cfg_key[1] = k1;
    cur_len = len;
    do_reset();
    base_w = wr_n;
    base_e = en_pulses;
    pulse_en(len);
    wait_done(tag);
    nw = wr_n - base_w;
    check({tag, "_rdy"},       32'(rdy),       32'd1);
    check({tag, "_key_valid"}, 32'(key_valid), 32'(exp_good));
    check({tag, "_key"},       32'(key),       32'(exp_key));
    check({tag, "_en_pulses"}, 32'(en_pulses - base_e), 32'd1);
    check({tag, "_n_writes"},  32'(nw), exp_good ? 32'(len) + 32'd1 : 32'd0);
    if (exp_good && nw > 0) begin
      errs = 0;
      for (int j = 0; j < nw; j++) begin
        if (wr_addr_log[base_w + j] !== 8'(j)) errs++;
        if (wr_data_log[base_w + j] !== mem_byte(exp_win, 8'(j))) errs++;
      end
      check({tag, "_wr_content_errs"}, 32'(errs), 32'd0);
      check({tag, "_wr_span_cycles"},
            32'(wr_cyc_log[base_w + nw - 1] - wr_cyc_log[base_w]), 32'(len));
    end
  endtask

  initial begin
    int base_e;
    bit seen;
    cfg_delay[0] = 0; cfg_delay[1] = 0;
    cfg_key[0] = '0;  cfg_key[1] = '0;

    // Reset state
    do_reset();
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_key", 32'(key), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_core_pt_addr", 32'(core_pt_addr), 32'd0);
    check("rst_pt_addr", 32'(pt_addr), 32'd0);
    check("rst_pt_wrdata", 32'(pt_wrdata), 32'd0);
    check("rst_pt_wren", 32'(pt_wren), 32'd0);

    // Core1 finds key late, core0 still busy
    run_case("c1_hit", 8'd5, 200, 1'b0, 24'h000099, 40, 1'b1, 24'h00002B,
             1'b1, 1, 24'h00002B);
    // Same-cycle hits: lower index wins
    run_case("tie", 8'd5, 10, 1'b1, 24'h000010, 10, 1'b1, 24'h000011,
             1'b1, 0, 24'h000010);
    // No key anywhere
    run_case("bad", 8'd5, 5, 1'b0, 24'h000001, 8, 1'b0, 24'h000002,
             1'b0, 0, 24'h000000);
    // en is ignored once terminal
    base_e = en_pulses;
    pulse_en(8'd3);
    repeat (4) @(negedge clk);
    check("bad_en_ignored_pulses", 32'(en_pulses - base_e), 32'd0);
    check("bad_en_ignored_kv", 32'(key_valid), 32'd0);
    // Boundary lengths
    run_case("len0", 8'd0, 3, 1'b1, 24'h0ABCDE, 6, 1'b0, 24'h000000,
             1'b1, 0, 24'h0ABCDE);
    run_case("len255", 8'd255, 4, 1'b0, 24'h000000, 2, 1'b1, 24'hFEDCBA,
             1'b1, 1, 24'hFEDCBA);

    // Start refused while core1 busy, then accepted
    cfg_delay[0] = 3; cfg_delay[1] = 3; cfg_hit = 2'b00;
    do_reset();
    force_busy = 2'b10;
    base_e = en_pulses;
    pulse_en(8'd4);
    repeat (5) @(negedge clk);
    check("busy_no_core_en", 32'(en_pulses - base_e), 32'd0);
    check("busy_stays_idle_rdy", 32'(rdy), 32'd1);
    force_busy = 2'b00;
    @(negedge clk);
    pulse_en(8'd4);
    check("start_core_en_value", 32'(core_en), 32'd3);
    wait_done("start_ok");
    check("start_one_pulse", 32'(en_pulses - base_e), 32'd1);
    check("start_last_en", 32'(last_en), 32'd3);

    // Reset in the middle of a copy
    cfg_delay[0] = 100; cfg_hit[0] = 1'b0;
    cfg_delay[1] = 6;   cfg_hit[1] = 1'b1; cfg_key[1] = 24'h123456;
    cur_len = 8'd5;
    do_reset();
    pulse_en(8'd5);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pt_wren && pt_addr == 8'd3) begin seen = 1'b1; break; end
    end
    check("midrst_reached_addr3", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pt_wren", 32'(pt_wren), 32'd0);
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_key", 32'(key), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
